// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_pkg;

  // Three-bit opcodes presented on mode together with start
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // Handshake FSM: idle/accepting, or iterating a multiply
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier engine: one partial product per step, WIDTH steps.
// Latency: WIDTH steps after load; acc_nxt on the step where last=1 is the full product.
// Backpressure: advances only when step=1, so the owner stalls it by withholding step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Multiplicand shifts left and multiplier shifts right, so bit 0 of the
  // multiplier register is always b[count] and mcand is always a<<count.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;

  // Partial-sum datapath and next-state for the iteration registers
  always_comb begin
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last     = (count_q == CW'(WIDTH - 1));
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      count_d  = '0;
    end else if (step) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_nxt;
      count_d  = count_q + CW'(1);
    end
  end

  // Iteration state registers, synchronously cleared
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with start/busy handshake and Z/C/N/V flags.
// Latency: 1 clk for single-cycle ops, WIDTH+1 clks for MUL (stretched by en=0 cycles).
// Backpressure: busy=1 during MUL; start is dropped (not queued) while busy or en=0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             fz,
  output logic             fc,
  output logic             fn,
  output logic             fv
);

  localparam int MSB = WIDTH - 1;

  alu_state_t state_q, state_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             fz_q, fz_d;
  logic             fc_q, fc_d;
  logic             fn_q, fn_d;
  logic             fv_q, fv_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;

  logic             accept;
  logic             wr;
  logic [WIDTH-1:0] new_sum;
  logic             new_c;
  logic             new_v;

  logic               mul_load;
  logic               mul_step;
  logic [2*WIDTH-1:0] mul_acc;
  logic               mul_last;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (mul_load),
    .step    (mul_step),
    .a       (in_a),
    .b       (in_b),
    .acc_nxt (mul_acc),
    .last    (mul_last)
  );

  assign busy   = (state_q == S_MUL_RUN);
  assign accept = en & start & ~busy;

  // Single-cycle results and their carry/overflow, computed straight off the operands
  always_comb begin
    add_ext = {1'b0, in_a} + {1'b0, in_b};
    sub_ext = {1'b0, in_a} - {1'b0, in_b};
    op_res  = '0;
    op_c    = 1'b0;
    op_v    = 1'b0;
    case (mode)
      OP_PASS: op_res = in_a;
      OP_ADD: begin
        op_res = add_ext[WIDTH-1:0];
        op_c   = add_ext[WIDTH];
        op_v   = (in_a[MSB] == in_b[MSB]) & (add_ext[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the zero-extended difference is the borrow
        op_res = sub_ext[WIDTH-1:0];
        op_c   = sub_ext[WIDTH];
        op_v   = (in_a[MSB] != in_b[MSB]) & (sub_ext[MSB] != in_a[MSB]);
      end
      OP_AND:  op_res = in_a & in_b;
      OP_OR:   op_res = in_a | in_b;
      OP_XOR:  op_res = in_a ^ in_b;
      OP_SHL1: begin
        op_res = {in_a[WIDTH-2:0], 1'b0};
        op_c   = in_a[MSB];
      end
      default: op_res = '0;
    endcase
  end

  // Handshake FSM, multiplier control and result/flag write-back
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    wr       = 1'b0;
    new_sum  = op_res;
    new_c    = op_c;
    new_v    = op_v;
    mul_load = 1'b0;
    mul_step = 1'b0;
    // en=0 freezes everything, including a pending done pulse
    if (en) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (mode == OP_MUL) begin
              mul_load = 1'b1;
              state_d  = S_MUL_RUN;
            end else begin
              wr = 1'b1;
            end
          end
        end
        S_MUL_RUN: begin
          mul_step = 1'b1;
          // The final iteration's sum goes straight to the result register
          if (mul_last) begin
            wr      = 1'b1;
            new_sum = mul_acc[WIDTH-1:0];
            new_c   = |mul_acc[2*WIDTH-1:WIDTH];
            new_v   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (wr) begin
        done_d = 1'b1;
      end
    end
    sum_d = wr ? new_sum : sum_q;
    fz_d  = wr ? (new_sum == '0) : fz_q;
    fn_d  = wr ? new_sum[MSB] : fn_q;
    fc_d  = wr ? new_c : fc_q;
    fv_d  = wr ? new_v : fv_q;
  end

  // State, result and flag registers; reset overrides en and aborts a running MUL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      fz_q    <= 1'b1;
      fc_q    <= 1'b0;
      fn_q    <= 1'b0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      fn_q    <= fn_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign sum  = sum_q;
  assign fz   = fz_q;
  assign fc   = fc_q;
  assign fn   = fn_q;
  assign fv   = fv_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=8): table vectors, handshake corner sequences, random ops vs model.
// Latency: checks 1 clk for single-cycle ops and WIDTH+1 (+en stalls) for MUL.
// Backpressure: exercises start-while-busy, en stalls, and accept on the done cycle.
module tb_alu_mc;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [2:0] mode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       fz;
  logic       fc;
  logic       fn;
  logic       fv;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic [3:0] f;   // {z,c,n,v}
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
  } exp_t;

  vec_t vt[12];

  alu_mc #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .mode  (mode),
    .in_a  (in_a),
    .in_b  (in_b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .fz    (fz),
    .fc    (fc),
    .fn    (fn),
    .fv    (fv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t ref_model(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    r = 0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (m)
      OP_PASS: r = ua;
      OP_ADD: begin
        r = ua + ub;
        e.c = (r > 255);
        sr = sa + sb;
        e.v = (sr > 127) || (sr < -128);
      end
      OP_SUB: begin
        r = ua - ub;
        e.c = (ua < ub);
        sr = sa - sb;
        e.v = (sr > 127) || (sr < -128);
      end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_SHL1: begin
        r = ua * 2;
        e.c = (r > 255);
      end
      default: begin
        r = ua * ub;
        e.c = (r > 255);
      end
    endcase
    r = r & 255;
    e.s = r[7:0];
    e.z = (r == 0);
    e.n = r[7];
    return e;
  endfunction

  // Issue one op, then wait for done; lat counts edges from accept to done.
  // inj: cycle to pulse a stray ADD start; en is low for en_len cycles from en_at.
  task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        input int inj, input int en_at, input int en_len,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; mode = m; in_a = a; in_b = b; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      start = (lat == inj);
      if (lat == inj) begin
        mode = OP_ADD; in_a = 8'h01; in_b = 8'h01;
      end
      en = !(lat >= en_at && lat < en_at + en_len);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    en = 1'b1;
  endtask

  task automatic do_check(input string tag, input logic [2:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] es, input logic [3:0] ef,
                          input int inj, input int en_at, input int en_len);
    int lat, bc, exp_lat, exp_bc;
    exp_lat = (m == OP_MUL) ? 9 + en_len : 1;
    exp_bc  = (m == OP_MUL) ? 8 + en_len : 0;
    run_op(m, a, b, inj, en_at, en_len, lat, bc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busycyc"}, bc, exp_bc);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_flags"}, {fz, fc, fn, fv}, ef);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat, bc, ndone;
    exp_t e;
    logic [2:0] rm;
    logic [7:0] ra, rb;

    vt[0]  = '{OP_ADD,  8'h05, 8'h0D, 8'h12, 4'b0000};
    vt[1]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b1100};
    vt[2]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0011};
    vt[3]  = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 4'b0110};
    vt[4]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0001};
    vt[5]  = '{OP_MUL,  8'h0D, 8'h05, 8'h41, 4'b0000};
    vt[6]  = '{OP_MUL,  8'h20, 8'h10, 8'h00, 4'b1100};
    vt[7]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000};
    vt[8]  = '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 4'b0010};
    vt[9]  = '{OP_XOR,  8'hAA, 8'hAA, 8'h00, 4'b1000};
    vt[10] = '{OP_SHL1, 8'h81, 8'h00, 8'h02, 4'b0100};
    vt[11] = '{OP_PASS, 8'h80, 8'h33, 8'h80, 4'b0010};

    rst_n = 1'b0; en = 1'b1; start = 1'b0; mode = OP_PASS; in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sum", sum, 8'h00);
    chk("rst_flags", {fz, fc, fn, fv}, 4'b1000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_check($sformatf("vec%0d", i), vt[i].m, vt[i].a, vt[i].b, vt[i].s, vt[i].f, -1, -1, 0);
    end

    // Reset mid-MUL: aborts with no done, outputs back to reset values
    do_check("pre_rst", OP_PASS, 8'h5A, 8'h00, 8'h5A, 4'b0000, -1, -1, 0);
    @(negedge clk);
    start = 1'b1; mode = OP_MUL; in_a = 8'h0D; in_b = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midmul_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_flags", {fz, fc, fn, fv}, 4'b1000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", ndone, 0);

    // Stray start while busy is ignored; en=0 stalls MUL by exactly the stall length
    do_check("mul_inj", OP_MUL, 8'h0D, 8'h05, 8'h41, 4'b0000, 3, -1, 0);
    do_check("mul_en", OP_MUL, 8'h0D, 8'h05, 8'h41, 4'b0000, -1, 3, 3);

    // done holds through en=0 and drops on the next enabled edge
    run_op(OP_ADD, 8'h01, 8'h02, -1, -1, 0, lat, bc);
    chk("hold_lat", lat, 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_done", done, 1'b1);
    chk("hold_sum", sum, 8'h03);
    en = 1'b1;
    @(negedge clk);
    chk("hold_drop", done, 1'b0);

    // Back-to-back: ADD accepted on the MUL done cycle
    run_op(OP_MUL, 8'h0D, 8'h05, -1, -1, 0, lat, bc);
    chk("b2b_lat", lat, 9);
    chk("b2b_mul_sum", sum, 8'h41);
    start = 1'b1; mode = OP_ADD; in_a = 8'h10; in_b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_add_sum", sum, 8'h32);
    @(negedge clk);
    chk("b2b_drop", done, 1'b0);

    // Random ops against the reference model
    for (int k = 0; k < 150; k++) begin
      rm = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      e = ref_model(rm, ra, rb);
      do_check($sformatf("rnd%0d", k), rm, ra, rb, e.s, {e.z, e.c, e.n, e.v}, -1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
